// File: rtl/atomrvcore_lsu.sv
// rtl/atomrvcore_lsu.sv - RV32I load/store unit bridging core requests to a dccm port
// Four-state FSM (IDLE/REQ/WAIT/RESP) with alignment checks, byte-lane steering and WAIT timeout.
module atomrvcore_lsu #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [2:0]           req_func3_i,
  input  logic [ADDRWIDTH-1:0] req_addr_i,
  input  logic [DATAWIDTH-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DATAWIDTH-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [2:0]             func3_q, func3_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   illegal, misaligned;
  logic [3:0]             be;
  logic [DATAWIDTH-1:0]   wdata_lanes, shifted, ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request screening: illegal encodings and misaligned H/W accesses never reach memory.
  always_comb begin
    illegal    = req_we_i ? (req_func3_i > 3'b010)
                          : (req_func3_i == 3'b011 || req_func3_i[2:1] == 2'b11);
    misaligned = (req_func3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                 (req_func3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          func3_d = req_func3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = illegal || misaligned;
          state_d = (illegal || misaligned) ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // rvalid takes priority over the timeout in the final cycle
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = '0;
    if (we_q) begin
      case (func3_q[1:0])
        2'b00: begin
          be          = 4'b0001 << addr_q[1:0];
          wdata_lanes = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be          = 4'b0011 << addr_q[1:0];
          wdata_lanes = {2{wdata_q[15:0]}};
        end
        default: wdata_lanes = wdata_q;
      endcase
    end
  end

  always_comb begin
    shifted = rdata_q >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'b000:  ext = {{(DATAWIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(DATAWIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {{(DATAWIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(DATAWIDTH-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    mem_req_o   = (state_q == REQ);
    rsp_valid_o = (state_q == RESP);
    mem_we_o    = mem_req_o && we_q;
    mem_be_o    = mem_req_o ? be : 4'b0000;
    mem_addr_o  = mem_req_o ? {addr_q[ADDRWIDTH-1:2], 2'b00} : '0;
    mem_wdata_o = mem_req_o ? wdata_lanes : '0;
    rsp_err_o   = rsp_valid_o && err_q;
    rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? ext : '0;
  end

endmodule

// File: doc/atomrvcore_lsu.md
ATOMRVCORE_LSU -- requirements
Module: atomRVCORE_lsu

Interface
REQ-001 Parameter DATAWIDTH, 32, data bus width in bits; only 32 is supported.
REQ-002 Parameter ADDRWIDTH, 32, byte-address width.
REQ-003 Parameter TIMEOUT, 16, maximum cycles spent in WAIT before an error response; legal range 2..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
REQ-005 Core-side ports SHALL be:
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = store, 0 = load.
- req_func3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr_i  in  ADDRWIDTH  byte address.
- req_wdata_i  in  DATAWIDTH  store data (rs2).
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATAWIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned, illegal funct3 or timeout.
REQ-006 Memory-side (dccm) ports SHALL be:
- mem_req_o  out  1.
- mem_gnt_i  in  1.
- mem_we_o  out  1.
- mem_be_o  out  4.
- mem_addr_o  out  ADDRWIDTH  word-aligned, bits[1:0]=0.
- mem_wdata_o  out  DATAWIDTH.
- mem_rvalid_i  in  1  read data valid / write ack.
- mem_rdata_i  in  DATAWIDTH.

Function
REQ-007 FSM states SHALL be IDLE, REQ, WAIT and RESP.
REQ-008 req_ready_o SHALL be 1 only in IDLE.
REQ-009 On a handshake, the block SHALL register we, func3, addr and wdata.
REQ-010 On a handshake, the next state SHALL be REQ, or RESP with err=1 if the request is misaligned or has an illegal funct3.
REQ-011 Misaligned SHALL mean: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
REQ-012 Illegal funct3 SHALL mean: loads 011/110/111; stores above 010.
REQ-013 An errored request SHALL never assert mem_req_o.
REQ-014 In REQ, mem_req_o SHALL be 1 with address, we, be and wdata held stable until mem_gnt_i=1; the next state is then WAIT.
REQ-015 REQ SHALL have no timeout.
REQ-016 In WAIT, mem_rvalid_i=1 SHALL latch mem_rdata_i and move to RESP.
REQ-017 The WAIT counter SHALL clear on entry and increment each cycle.
REQ-018 When the count reaches TIMEOUT-1 with no rvalid, the next state SHALL be RESP with err=1 and rdata=0.
REQ-019 If rvalid arrives in the same cycle the count reaches TIMEOUT-1, rvalid SHALL win and the response is not an error.
REQ-020 RESP SHALL assert rsp_valid_o for exactly one cycle, then go to IDLE; a new request SHALL not be accepted in RESP.
REQ-021 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-022 mem_be_o SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-023 mem_wdata_o SHALL be: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-024 Load data SHALL be extracted as rdata>>(8*addr[1:0]).
REQ-025 LB/LH SHALL sign-extend bit 7/15; LBU/LHU SHALL zero-extend; LW SHALL pass through.
REQ-026 Best-case latency SHALL be 3 cycles, handshake to rsp_valid_o (gnt and rvalid each in the first cycle offered).
REQ-027 The error path latency SHALL be 1 cycle.
REQ-028 Outputs other than req_ready_o, mem_req_o and rsp_valid_o SHALL be 0 whenever the corresponding strobe is low.

Reset
REQ-029 While rst_i=1: state IDLE, counter 0, all registered fields 0, and all outputs 0 except req_ready_o=1.
REQ-030 Reset asserted mid-transaction SHALL abort it with no response; a rvalid arriving after reset release SHALL be ignored.

Verification
REQ-031 LB addr 0x103, mem_rdata 0x80FF_1234 -> mem_addr 0x100, be 1111/we0, rsp_rdata 0xFFFF_FF80, err0.
REQ-032 SH addr 0x202, wdata 0x0000_BEEF -> mem_be 1100, mem_wdata 0xBEEF_BEEF, mem_we1, rsp_rdata 0.
REQ-033 LW addr 0x105 -> rsp_valid 1 cycle after handshake, err1, mem_req never high.
REQ-034 LHU addr 0x40, gnt held low 5 cycles, rvalid later, rdata 0x0000_9ABC -> mem_req/addr stable throughout, rsp_rdata 0x0000_9ABC.
REQ-035 LW, gnt given, rvalid never -> rsp_valid with err1, rdata 0 after TIMEOUT cycles in WAIT; a later stray rvalid in IDLE produces no response.
REQ-036 rst_i pulsed while in WAIT -> req_ready_o=1 and rsp_valid_o=0 immediately, no response issued.
